fetch_sequencer: RTL and testbench

Fetch-control stage for the A09 datapath. Sits between the program counter and the instruction ROM on one side, and the output register and decode logic on the other. It holds off every ROM access until a post-configuration delay has elapsed, which covers the iCE40 BRAM initialisation window. After that it sequences fetches in either single-step or free-run mode: it enables the memory, captures the read word into an instruction register, then pulses the PC increment.

---
 rtl/fetch_sequencer_pkg.sv | 19 +
 rtl/fetch_sequencer_rising_edge_detect.sv | 27 ++
 rtl/fetch_sequencer.sv | 118 +++++++++++
 tb/tb_fetch_sequencer.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the A09 fetch path: FSM encoding, active-low control
// levels and default sizing.
package fetch_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_BOOT  = 2'd0,
    ST_IDLE  = 2'd1,
    ST_FETCH = 2'd2,
    ST_LATCH = 2'd3
  } fetch_state_e;

  localparam logic ASSERT_N   = 1'b0;
  localparam logic DEASSERT_N = 1'b1;

  // 3 us at 16 MHz covers the iCE40 BRAM initialisation window
  localparam int DEFAULT_BOOT_DELAY = 48;
  localparam int DEFAULT_DATA_W     = 16;

endpackage

// File: rtl/fetch_sequencer_rising_edge_detect.sv
// One-cycle pulse on each 0->1 transition of a synchronous level input.
// Kept generic so manual-clock and button inputs can reuse it.
module rising_edge_detect (
  input  logic Clk,
  input  logic Reset,
  input  logic Level,
  output logic Pulse
);

  logic level_q;
  logic level_d;

  always_comb begin
    level_d = Level;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      level_q <= 1'b0;
    end else begin
      level_q <= level_d;
    end
  end

  assign Pulse = Level & ~level_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch-control stage: waits out the BRAM boot window, then sequences
// FETCH -> LATCH -> IDLE fetches in single-step or free-run mode.
module fetch_sequencer
  import fetch_sequencer_pkg::*;
#(
  parameter int DataWidth       = DEFAULT_DATA_W,
  parameter int BootDelayCycles = DEFAULT_BOOT_DELAY
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic                 Run,
  input  logic                 Step,
  input  logic [DataWidth-1:0] MemData,
  output logic                 Mem_En,
  output logic                 PC_Inc,
  output logic [DataWidth-1:0] IR,
  output logic                 IR_Valid,
  output logic                 Ready,
  output logic [1:0]           State
);

  localparam int CntW = $clog2(BootDelayCycles + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(BootDelayCycles - 1);

  fetch_state_e         state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 pend_q, pend_d;
  logic                 ready_q, ready_d;
  logic                 mem_en_q, mem_en_d;
  logic                 pc_inc_q, pc_inc_d;
  logic [DataWidth-1:0] ir_q, ir_d;
  logic                 ir_valid_q, ir_valid_d;
  logic                 step_pulse;
  logic                 go;

  rising_edge_detect u_step_edge (
    .Clk   (Clk),
    .Reset (Reset),
    .Level (Step),
    .Pulse (step_pulse)
  );

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    ready_d    = ready_q;
    ir_d       = ir_q;
    ir_valid_d = 1'b0;
    go         = 1'b0;

    unique case (state_q)
      ST_BOOT: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CntLast) begin
          state_d = ST_IDLE;
          ready_d = 1'b1;
        end
      end
      ST_IDLE: begin
        if (Run || pend_q) begin
          go      = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_LATCH;
      ST_LATCH: begin
        ir_d       = MemData;
        ir_valid_d = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_BOOT;
    endcase

    // The fetch launch consumes any pending step, including one arriving on
    // the same edge; boot-time edges are dropped rather than queued.
    pend_d = pend_q;
    if (go) begin
      pend_d = 1'b0;
    end else if (step_pulse && (state_q != ST_BOOT)) begin
      pend_d = 1'b1;
    end

    // Strobes are registered from the next state so they depend on FSM state
    // alone and cannot glitch with Run/Step.
    mem_en_d = (state_d == ST_FETCH) ? ASSERT_N : DEASSERT_N;
    pc_inc_d = (state_d == ST_LATCH) ? ASSERT_N : DEASSERT_N;
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state_q    <= ST_BOOT;
      cnt_q      <= '0;
      pend_q     <= 1'b0;
      ready_q    <= 1'b0;
      mem_en_q   <= DEASSERT_N;
      pc_inc_q   <= DEASSERT_N;
      ir_q       <= '0;
      ir_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      pend_q     <= pend_d;
      ready_q    <= ready_d;
      mem_en_q   <= mem_en_d;
      pc_inc_q   <= pc_inc_d;
      ir_q       <= ir_d;
      ir_valid_q <= ir_valid_d;
    end
  end

  assign Mem_En   = mem_en_q;
  assign PC_Inc   = pc_inc_q;
  assign IR       = ir_q;
  assign IR_Valid = ir_valid_q;
  assign Ready    = ready_q;
  assign State    = state_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Scoreboard bench for fetch_sequencer: a behavioural model predicts every
// cycle's outputs into a queue, and a monitor compares them against the DUT.
module tb_fetch_sequencer;

  localparam int DW   = 16;
  localparam int BOOT = 4;

  logic          Clk;
  logic          Reset;
  logic          Run;
  logic          Step;
  logic [DW-1:0] MemData;
  logic          Mem_En;
  logic          PC_Inc;
  logic [DW-1:0] IR;
  logic          IR_Valid;
  logic          Ready;
  logic [1:0]    State;

  fetch_sequencer #(.DataWidth(DW), .BootDelayCycles(BOOT)) dut (
    .Clk      (Clk),
    .Reset    (Reset),
    .Run      (Run),
    .Step     (Step),
    .MemData  (MemData),
    .Mem_En   (Mem_En),
    .PC_Inc   (PC_Inc),
    .IR       (IR),
    .IR_Valid (IR_Valid),
    .Ready    (Ready),
    .State    (State)
  );

  typedef struct packed {
    logic [1:0]    st;
    logic          mem_en;
    logic          pc_inc;
    logic [DW-1:0] ir;
    logic          ir_valid;
    logic          ready;
  } snap_t;

  snap_t exp_q[$];
  int checks   = 0;
  int failures = 0;

  // Model state: edges counted since reset release, and a phase 1..3 meaning
  // waiting / memory enabled / PC increment once booted.
  int            m_cycles;
  bit            m_ready;
  int            m_phase;
  bit            m_pend;
  bit            m_prev_step;
  logic [DW-1:0] m_ir;
  bit            m_valid;

  function automatic snap_t reset_snap();
    snap_t s;
    s.st = 2'd0; s.mem_en = 1'b1; s.pc_inc = 1'b1;
    s.ir = '0;   s.ir_valid = 1'b0; s.ready = 1'b0;
    return s;
  endfunction

  task automatic model_reset();
    m_cycles = 0; m_ready = 0; m_phase = 0; m_pend = 0;
    m_prev_step = 0; m_ir = '0; m_valid = 0;
  endtask

  task automatic model_edge();
    bit    step_rise;
    bit    was_ready;
    snap_t s;
    step_rise   = Step && !m_prev_step;
    m_prev_step = Step;
    was_ready   = m_ready;
    m_valid     = 0;
    if (!m_ready) begin
      m_cycles++;
      if (m_cycles == BOOT) begin
        m_ready = 1;
        m_phase = 1;
      end
    end else if (m_phase == 1) begin
      if (Run || m_pend) begin
        m_phase   = 2;
        m_pend    = 0;
        step_rise = 0;
      end
    end else if (m_phase == 2) begin
      m_phase = 3;
    end else begin
      m_ir    = MemData;
      m_valid = 1;
      m_phase = 1;
    end
    if (was_ready && step_rise) m_pend = 1;
    s.st       = 2'(m_phase);
    s.mem_en   = !(m_phase == 2);
    s.pc_inc   = !(m_phase == 3);
    s.ir       = m_ir;
    s.ir_valid = m_valid;
    s.ready    = m_ready;
    exp_q.push_back(s);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
    end
  endtask

  task automatic cmp_snap(input string name, input snap_t a, input snap_t e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s at %0t: got st=%0d men=%b pci=%b ir=%h v=%b rdy=%b, expected st=%0d men=%b pci=%b ir=%h v=%b rdy=%b",
               name, $time, a.st, a.mem_en, a.pc_inc, a.ir, a.ir_valid, a.ready,
               e.st, e.mem_en, e.pc_inc, e.ir, e.ir_valid, e.ready);
    end
  endtask

  initial begin
    Clk = 1'b0;
    forever #5 Clk = ~Clk;
  end

  initial begin
    model_reset();
    forever begin
      @(posedge Clk);
      if (!Reset) begin
        model_reset();
        exp_q.push_back(reset_snap());
      end else begin
        model_edge();
      end
    end
  end

  // An asynchronous reset invalidates whatever was predicted for this cycle.
  initial begin
    forever begin
      @(negedge Reset);
      exp_q.delete();
      model_reset();
    end
  end

  initial begin
    snap_t act;
    snap_t e;
    forever begin
      @(negedge Clk);
      act = {State, Mem_En, PC_Inc, IR, IR_Valid, Ready};
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        cmp_snap("scoreboard", act, e);
      end else if (!Reset) begin
        cmp_snap("async_reset_state", act, reset_snap());
      end else begin
        chk("scoreboard_underflow", 32'd1, 32'd0);
      end
    end
  end

  task automatic wait_state(input string name, input logic [1:0] s, input int bound);
    int n;
    n = 0;
    while (State !== s && n < bound) begin
      @(negedge Clk);
      n++;
    end
    chk(name, 32'(State), 32'(s));
  endtask

  initial begin
    int pulses;
    Run = 1'b0; Step = 1'b0; MemData = '0; Reset = 1'b0;
    repeat (3) @(posedge Clk);
    #2 Reset = 1'b1;

    // Boot with a step edge on the second boot edge; it must be discarded.
    pulses = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      Step = (i == 1);
      if (i < 4) chk("boot_ready_low", 32'(Ready), 32'd0);
      if (IR_Valid) pulses++;
    end
    chk("boot_ready_high", 32'(Ready), 32'd1);
    chk("boot_step_dropped_state", 32'(State), 32'd1);
    chk("boot_step_no_fetch", 32'(pulses), 32'd0);

    // Single step latching 16'hA5C3.
    Step = 1'b1; MemData = 16'hA5C3;
    @(negedge Clk);
    Step = 1'b0;
    pulses = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge Clk);
      if (IR_Valid) pulses++;
    end
    chk("step_ir", 32'(IR), 32'hA5C3);
    chk("step_one_valid", 32'(pulses), 32'd1);
    chk("step_parks_idle", 32'(State), 32'd1);

    // Free run for nine cycles, one instruction every three.
    pulses = 0;
    for (int i = 1; i <= 9; i++) begin
      MemData = DW'((i + 2) / 3);
      Run = 1'b1;
      @(negedge Clk);
      if (!PC_Inc) pulses++;
    end
    Run = 1'b0;
    chk("run_pc_inc_pulses", 32'(pulses), 32'd3);
    chk("run_ir_final", 32'(IR), 32'h0003);

    // Two step edges during one fetch produce exactly one extra fetch.
    repeat (2) @(negedge Clk);
    pulses = 0;
    Step = 1'b1;
    @(negedge Clk);
    Step = 1'b0;
    wait_state("wait_fetch", 2'd2, 10);
    Step = 1'b1;
    @(negedge Clk);
    if (IR_Valid) pulses++;
    Step = 1'b0;
    @(negedge Clk);
    if (IR_Valid) pulses++;
    Step = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(negedge Clk);
      Step = 1'b0;
      MemData = DW'($urandom);
      if (IR_Valid) pulses++;
    end
    chk("double_step_fetches", 32'(pulses), 32'd2);
    chk("double_step_parks", 32'(State), 32'd1);

    // Reset in the middle of LATCH.
    Run = 1'b1;
    wait_state("wait_latch", 2'd3, 10);
    #1 Reset = 1'b0;
    Run = 1'b0;
    #1;
    chk("rst_pc_inc", 32'(PC_Inc), 32'd1);
    chk("rst_mem_en", 32'(Mem_En), 32'd1);
    chk("rst_state", 32'(State), 32'd0);
    chk("rst_ir", 32'(IR), 32'd0);
    chk("rst_ready", 32'(Ready), 32'd0);
    repeat (2) @(posedge Clk);
    #2 Reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge Clk);
      chk("reboot_ready", 32'(Ready), (i == 4) ? 32'd1 : 32'd0);
    end

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      @(negedge Clk);
      Run     = ($urandom_range(0, 3) == 0);
      Step    = ($urandom_range(0, 2) == 0);
      MemData = DW'($urandom);
      if ($urandom_range(0, 149) == 0) begin
        #1 Reset = 1'b0;
        repeat ($urandom_range(1, 3)) @(posedge Clk);
        #2 Reset = 1'b1;
      end
    end

    Run = 1'b0; Step = 1'b0;
    repeat (10) @(negedge Clk);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
